// File: rtl/std_binary_encoder_stream_pkg.sv
// std_binary_encoder_stream_pkg: shared types for the streaming binary encoder.
package std_binary_encoder_stream_pkg;
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
endpackage

// File: rtl/std_bit_finder.sv
// std_bit_finder: combinational index of the lowest (or highest) set bit of a vector.
module std_bit_finder #(
    parameter int W = 256,
    parameter int BW = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [W-1:0]  vec,
    output logic [BW-1:0] idx,
    output logic          found
);
    // Later loop iterations win, so the scan runs away from the preferred end.
    always_comb begin
        idx = '0;
        found = |vec;
        for (int i = 0; i < W; i++) begin
            if (MSB_FIRST ? vec[i] : vec[W-1-i]) idx = MSB_FIRST ? BW'(i) : BW'(W-1-i);
        end
    end
endmodule

// File: rtl/std_binary_encoder_stream.sv
// std_binary_encoder_stream: serializes each set bit of a multi-hot vector into binary indices.
// Define STD_BINARY_ENCODER_STREAM_MSB_FIRST_EN to emit highest set bit first.
module std_binary_encoder_stream
    import std_binary_encoder_stream_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int UNARY_WIDTH = 1 << BIN_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [UNARY_WIDTH-1:0] i_unary,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BIN_WIDTH-1:0]   o_bin,
    output logic                   o_last,
    output logic                   o_empty
);
`ifdef STD_BINARY_ENCODER_STREAM_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    state_t                 state, state_d;
    logic [UNARY_WIDTH-1:0] pending, pending_d;
    logic                   empty_q, empty_d;
    logic [BIN_WIDTH-1:0]   idx;
    logic                   found, last, take, acc;

    std_bit_finder #(.W(UNARY_WIDTH), .BW(BIN_WIDTH), .MSB_FIRST(MSB_FIRST)) u_finder (
        .vec(pending),
        .idx(idx),
        .found(found)
    );

    assign last = (pending & (pending - 1'b1)) == '0;
    assign take = i_en && o_valid && i_ready;
    assign acc  = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            pending <= '0;
            empty_q <= 1'b0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            empty_q <= empty_d;
        end
    end

    // A new vector accepted on the last beat overrides the return to IDLE.
    always_comb begin
        state_d = state;
        pending_d = pending;
        empty_d = empty_q;
        if (take) begin
            pending_d = found ? pending & ~(UNARY_WIDTH'(1) << idx) : pending;
            state_d = last ? IDLE : SCAN;
        end
        if (acc) begin
            pending_d = i_unary;
            empty_d = i_unary == '0;
            state_d = SCAN;
        end
    end

    always_comb begin
        o_valid = state == SCAN;
        o_bin = o_valid ? idx : '0;
        o_last = o_valid && last;
        o_empty = o_valid && empty_q;
        o_ready = i_en && (!o_valid || (i_ready && last));
    end
endmodule

// File: tb/tb_std_binary_encoder_stream.sv
// tb_std_binary_encoder_stream: scoreboard bench for the streaming binary encoder.
module tb_std_binary_encoder_stream;
    localparam int BW = 8;
    localparam int UW = 256;

    typedef struct packed {
        logic [BW-1:0] bin;
        logic          last;
        logic          empty;
    } beat_t;

    logic          i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
    logic [UW-1:0] i_unary = '0;
    logic          o_ready, o_valid, o_last, o_empty;
    logic [BW-1:0] o_bin;

    beat_t         exp_q[$];
    logic [UW-1:0] vec_q[$];
    logic [UW-1:0] recon = '0;
    int            checks = 0, errors = 0;
    bit            rand_on = 1'b0;

    std_binary_encoder_stream #(.BIN_WIDTH(BW), .UNARY_WIDTH(UW)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_unary(i_unary),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_bin(o_bin),
        .o_last(o_last),
        .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void push_vec(input logic [UW-1:0] v);
        int cnt, k, i;
        cnt = $countones(v);
        k = 0;
        vec_q.push_back(v);
        if (cnt == 0) exp_q.push_back(beat_t'({BW'(0), 1'b1, 1'b1}));
        for (int j = 0; j < UW; j++) begin
`ifdef STD_BINARY_ENCODER_STREAM_MSB_FIRST_EN
            i = UW - 1 - j;
`else
            i = j;
`endif
            if (v[i]) begin
                k++;
                exp_q.push_back(beat_t'({BW'(i), k == cnt, 1'b0}));
            end
        end
    endfunction

    // Every transferred beat is popped from the scoreboard; the OR of beats is checked per vector.
    always @(negedge i_clk) begin
        beat_t         e;
        logic [UW-1:0] v;
        if (!i_rst && o_valid && i_ready && i_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat bin=%0d last=%0b", o_bin, o_last);
            end else begin
                e = exp_q.pop_front();
                if ({o_bin, o_last, o_empty} !== e) begin
                    errors++;
                    $display("FAIL beat got bin=%0d last=%0b empty=%0b expected bin=%0d last=%0b empty=%0b",
                             o_bin, o_last, o_empty, e.bin, e.last, e.empty);
                end
            end
            if (!o_empty) recon[o_bin] = 1'b1;
            if (o_last) begin
                checks++;
                v = vec_q.size() != 0 ? vec_q.pop_front() : ~recon;
                if (recon !== v) begin
                    errors++;
                    $display("FAIL recon got %h expected %h", recon, v);
                end
                recon = '0;
            end
        end
    end

    always @(posedge i_clk) begin
        if (rand_on) begin
            #1;
            i_ready = $urandom_range(0, 3) != 0;
            i_en = $urandom_range(0, 5) != 0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [UW-1:0] v, output logic busy, output logic [BW-1:0] bin_at);
        int n = 0;
        i_unary = v;
        i_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_ready || n > 2000) break;
            n++;
        end
        checks++;
        if (n > 2000) begin
            errors++;
            $display("FAIL send_timeout o_ready=%0b expected 1", o_ready);
        end
        busy = o_valid;
        bin_at = o_bin;
        push_vec(v);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({o_valid, o_bin, o_last, o_empty} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b bin=%0d last=%0b empty=%0b expected all 0",
                     o_valid, o_bin, o_last, o_empty);
        end
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b expected 1", o_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [UW-1:0] v;
        logic          b;
        logic [BW-1:0] bb;
        logic [BW-1:0] e[3];
        v = '0;
        v[3] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
        e[0] = 3; e[1] = 17; e[2] = 255;
        send(v, b, bb);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b1 || o_bin !== e[k] || o_last !== (k == 2)) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%0b bin=%0d last=%0b expected v=1 bin=%0d last=%0b",
                         k, o_valid, o_bin, o_last, e[k], k == 2);
            end
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_ready got %0b expected 1", o_ready);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [UW-1:0] v;
        logic          b;
        logic [BW-1:0] bb;
        v = '0;
        v[3] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
        send(v, b, bb);
        @(negedge i_clk);
        checks++;
        if (o_bin !== 8'd3) begin
            errors++;
            $display("FAIL bp_first got %0d expected 3", o_bin);
        end
        tick();
        i_ready = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b1 || o_bin !== 8'd17 || o_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got v=%0b bin=%0d last=%0b expected v=1 bin=17 last=0",
                         o_valid, o_bin, o_last);
            end
        end
        tick();
        i_ready = 1'b1;
        drain();
    endtask

    task automatic test_zero();
        logic          b;
        logic [BW-1:0] bb;
        send('0, b, bb);
        @(negedge i_clk);
        checks++;
        if ({o_valid, o_bin, o_last, o_empty, o_ready} !== {1'b1, 8'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_beat got v=%0b bin=%0d last=%0b empty=%0b rdy=%0b expected 1 0 1 1 1",
                     o_valid, o_bin, o_last, o_empty, o_ready);
        end
        drain();
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got rdy=%0b v=%0b expected rdy=1 v=0", o_ready, o_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic          b;
        logic [BW-1:0] bb;
        logic [UW-1:0] v;
        v = '0;
        v[42] = 1'b1;
        send('1, b, bb);
        send(v, b, bb);
        checks++;
        if (b !== 1'b1 || bb !== 8'd255) begin
            errors++;
            $display("FAIL b2b_accept got busy=%0b bin=%0d expected busy=1 bin=255", b, bb);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_bin !== 8'd42 || o_last !== 1'b1 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL b2b_next got v=%0b bin=%0d last=%0b empty=%0b expected 1 42 1 0",
                     o_valid, o_bin, o_last, o_empty);
        end
        drain();
    endtask

    task automatic test_reset_mid_scan();
        logic [UW-1:0] v;
        logic          b;
        logic [BW-1:0] bb;
        v = '0;
        v[1] = 1'b1; v[5] = 1'b1; v[9] = 1'b1; v[200] = 1'b1;
        send(v, b, bb);
        @(negedge i_clk);
        @(negedge i_clk);
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_bin, o_last} !== '0) begin
            errors++;
            $display("FAIL rst_mid got v=%0b bin=%0d last=%0b expected 0 0 0", o_valid, o_bin, o_last);
        end
        exp_q.delete();
        vec_q.delete();
        recon = '0;
        tick();
        i_rst = 1'b0;
        v = '0;
        v[7] = 1'b1; v[9] = 1'b1;
        send(v, b, bb);
        @(negedge i_clk);
        checks++;
        if (o_bin !== 8'd7 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_clean got bin=%0d last=%0b expected 7 0", o_bin, o_last);
        end
        drain();
    endtask

    task automatic test_random();
        logic [UW-1:0] v;
        logic          b;
        logic [BW-1:0] bb;
        rand_on = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < UW; i++) v[i] = $urandom_range(0, 15) == 0;
            if (n % 7 == 3) v = '0;
            send(v, b, bb);
        end
        rand_on = 1'b0;
        @(posedge i_clk);
        #2;
        i_ready = 1'b1;
        i_en = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/std_binary_encoder_stream.md
Name: std_binary_encoder_stream

Overview:
- Sequential binary encoder: accepts a UNARY_WIDTH-bit vector over a valid/ready handshake.
- Emits the binary index of every set bit, one index per output handshake, LSB-first, with a last flag.
- Counterpart of std_binary_decoder: feeding every emitted index through the decoder and OR-ing the results reconstructs the input vector.
- Used wherever a multi-hot request/status vector must be serialized into indices.

Parameters:
- BIN_WIDTH, 8, width of the emitted index.
- UNARY_WIDTH, 1 << BIN_WIDTH, width of the input vector; must be greater than 1 and no more than 1 << BIN_WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_en  input  1  enable; when 0, all state frozen, o_ready=0, o_valid held.
- i_valid  input  1  input vector valid.
- o_ready  output  1  input vector accepted when i_valid && o_ready.
- i_unary  input  UNARY_WIDTH  input vector.
- o_valid  output  1  output index valid.
- i_ready  input  1  sink accepts index when o_valid && i_ready.
- o_bin  output  BIN_WIDTH  emitted index.
- o_last  output  1  final beat for the current vector.
- o_empty  output  1  current vector was all-zero.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, pending=0, o_valid=0, o_bin=0, o_last=0, o_empty=0; o_ready=1 once i_rst is low (and i_en=1).
- States: IDLE, SCAN.
- IDLE:
  - o_valid=0, o_ready=i_en.
  - On accept: pending<=i_unary, empty flag<=(i_unary==0), go to SCAN.
- SCAN:
  - o_valid=1.
  - o_bin=index of the lowest set bit of pending.
  - o_last=(pending & (pending-1))==0.
  - o_empty=empty flag.
  - On output handshake: clear that bit in pending. If o_last, go to IDLE, unless a new vector is accepted in the same cycle (see Throughput).
- Latency: first o_valid in the cycle after input accept. One beat per cycle while i_ready=1, so popcount beats for a vector with N set bits.
- Zero vector: exactly one beat with o_bin=0, o_last=1, o_empty=1. Every accepted vector therefore yields at least one beat.
- Backpressure: while o_valid && !i_ready, o_bin/o_last/o_empty are held stable.
- Throughput:
  - o_ready = i_en && ((state==IDLE) || (o_valid && i_ready && o_last)).
  - A new vector may be accepted in the cycle its predecessor's last beat is taken; the next cycle shows the new vector's first beat. This is a combinational path i_ready -> o_ready.
- i_en=0 mid-scan: no state change and no handshakes; o_valid stays 1 with outputs held. The sink must not treat the beat as transferred until i_en=1 and i_ready=1.
- Bits at positions >= UNARY_WIDTH never appear on o_bin.
- Reset mid-scan: remaining bits are discarded; no further beats for that vector.

Optional Feature:
- Macro: STD_BINARY_ENCODER_STREAM_MSB_FIRST_EN.
- Defined: scan order is highest set bit first. o_last is still asserted when exactly one bit remains; the zero-vector beat is unchanged.
- Undefined: LSB-first as specified above.

Decomposition:
- Package std_binary_encoder_stream_pkg: state enum type (IDLE, SCAN).
- Sub-module std_bit_finder (combinational):
  - Input: vector.
  - Outputs: index of lowest set bit, found flag.
  - Parameter selects lowest or highest, driven by the macro.
  - Instantiated once on pending.

Test Plan:
- Reset: assert i_rst mid-cycle -> o_valid=0, o_bin=0, o_last=0 immediately; o_ready=1 after release with i_en=1.
- BIN_WIDTH=8, i_unary with bits {3,17,255} set, i_ready=1 -> beats 3, 17, 255 on consecutive cycles; o_last only on 255; o_ready=1 in the last-beat cycle.
- Same vector with i_ready low for 3 cycles on the second beat -> o_bin=17 held, o_valid=1, no skipped or duplicated index.
- i_unary=0 -> one beat: o_bin=0, o_last=1, o_empty=1; then ready.
- All-ones, then the one-hot vector with bit 42 offered during the last beat -> 256 beats 0..255, last at 255. Bit 42 is accepted in that cycle and its beat (42, o_last=1) follows next cycle. Decoding all beats through std_binary_decoder and OR-ing reproduces each input.
- Vector {1,5,9,200}: after 2 beats, pulse i_rst -> o_valid drops asynchronously, 9 and 200 are never emitted, next vector starts clean.
